// File: rtl/square_iterate.sv
// -----------------------------------------------------------------------------
// square_iterate
//
// Iterative squarer for the unpacked half-precision field format shared with
// the sqrt iteration stage. Takes a sign / 11-bit mantissa / signed 7-bit
// exponent plus special flags, computes x*x with a shift-add multiplier
// (one step per mantissa bit) and returns the result in the same format.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   enable            synchronous run enable; low clears all state
//   n_valid           input fields valid, accepted only when idle
//   is_nan_in         input is NaN
//   is_pinf_in        input is +inf
//   is_ninf_in        input is -inf
//   is_num            input is a legal number
//   sign_in           input sign (a square is always positive)
//   mant_in[10:0]     bit10 integer bit, bits 9:0 fraction
//   exp_in[6:0]       signed exponent; -15 zero/subnormal, 16 special
//   it_valid          operation in flight, or result cycle
//   result            one-cycle pulse, output fields valid
//   sign_out          result sign
//   exp_out[6:0]      result exponent, signed
//   mant_out[10:0]    result mantissa
//   is_nan_out        result is NaN
//   is_pinf_out       result is +inf
//   is_ninf_out       always 0
// -----------------------------------------------------------------------------
module square_iterate #(
  parameter int ITER_MAX = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        n_valid,
  input  logic        is_nan_in,
  input  logic        is_pinf_in,
  input  logic        is_ninf_in,
  input  logic        is_num,
  input  logic        sign_in,
  input  logic [10:0] mant_in,
  input  logic [6:0]  exp_in,
  output logic        it_valid,
  output logic        result,
  output logic        sign_out,
  output logic [6:0]  exp_out,
  output logic [10:0] mant_out,
  output logic        is_nan_out,
  output logic        is_pinf_out,
  output logic        is_ninf_out
);

  localparam int MW = 11;          // mantissa width
  localparam int PW = 2 * MW;      // product width
  localparam int CW = $clog2(ITER_MAX + 1);

  localparam logic [6:0]    EXP_ZERO    = 7'h71;  // -15
  localparam logic [6:0]    EXP_SPECIAL = 7'h10;  // +16
  localparam logic [MW-1:0] MANT_ONE    = 11'h400;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  typedef enum logic [1:0] {
    K_NAN,
    K_INF,
    K_ZERO,
    K_NUM
  } kind_t;

  typedef struct packed {
    logic          sign;
    logic [6:0]    exp;
    logic [MW-1:0] mant;
    logic          nan;
    logic          pinf;
  } fields_t;

  // Fixed encodings for the three non-numeric result classes.
  function automatic fields_t special_fields(input kind_t k);
    fields_t f;
    f = '0;
    case (k)
      K_NAN: begin
        f.sign = 1'b1;
        f.exp  = EXP_SPECIAL;
        f.mant = MANT_ONE;
        f.nan  = 1'b1;
      end
      K_INF: begin
        f.exp  = EXP_SPECIAL;
        f.pinf = 1'b1;
      end
      default: begin
        f.exp  = EXP_ZERO;
      end
    endcase
    return f;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t               state_reg,     state_next;
  logic [CW-1:0]        count_reg,     count_next;
  logic [PW-1:0]        mcand_reg,     mcand_next;
  logic [MW-1:0]        mplier_reg,    mplier_next;
  logic [PW-1:0]        prod_reg,      prod_next;
  logic signed [7:0]    exp2_reg,      exp2_next;
  logic                 pend_reg,      pend_next;
  kind_t                pend_kind_reg, pend_kind_next;
  fields_t              out_reg,       out_next;
  logic                 result_reg,    result_next;
  logic                 it_valid_reg,  it_valid_next;

  // The sign never reaches the output: a square is always positive.
  logic unused_sign;
  assign unused_sign = sign_in;

  // ---------------------------------------------------------------------------
  // Input classification (priority NaN > INF > ZERO > NUM)
  // ---------------------------------------------------------------------------
  kind_t in_kind;

  always_comb begin
    in_kind = K_NUM;
    if (is_nan_in || !is_num) begin
      in_kind = K_NAN;
    end else if (is_pinf_in || is_ninf_in) begin
      in_kind = K_INF;
    end else if (exp_in == EXP_ZERO) begin
      // Subnormals share this exponent; their squares underflow anyway.
      in_kind = K_ZERO;
    end
  end

  logic accept;
  assign accept = enable && n_valid && (state_reg == S_IDLE);

  // ---------------------------------------------------------------------------
  // Shift-add datapath
  // ---------------------------------------------------------------------------
  // mcand_reg is shifted left once per step, so it always holds the
  // multiplicand pre-shifted by the current iteration index.
  logic [PW-1:0]     addend;
  logic [PW-1:0]     prod_sum;
  logic              final_iter;
  logic signed [7:0] e_norm;
  logic [MW-1:0]     mant_norm;
  fields_t           num_fields;

  assign addend     = mplier_reg[0] ? mcand_reg : '0;
  assign prod_sum   = prod_reg + addend;
  assign final_iter = (state_reg == S_RUN) && (count_reg == CW'(1));

  // Normalise the completed product P/2^20 in [1,4) and range-check the
  // exponent in 8-bit signed so nothing wraps before the comparison.
  always_comb begin
    if (prod_sum[PW-1]) begin
      mant_norm = prod_sum[PW-1 -: MW];
      e_norm    = exp2_reg + 8'sd1;
    end else begin
      mant_norm = prod_sum[PW-2 -: MW];
      e_norm    = exp2_reg;
    end

    if (e_norm > 8'sd15) begin
      num_fields = special_fields(K_INF);
    end else if (e_norm < -8'sd14) begin
      num_fields = special_fields(K_ZERO);
    end else begin
      num_fields      = '0;
      num_fields.exp  = e_norm[6:0];
      num_fields.mant = mant_norm;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    mcand_next     = mcand_reg;
    mplier_next    = mplier_reg;
    prod_next      = prod_reg;
    exp2_next      = exp2_reg;
    pend_next      = 1'b0;
    pend_kind_next = pend_kind_reg;
    out_next       = out_reg;
    result_next    = 1'b0;
    it_valid_next  = 1'b0;

    if (!enable) begin
      // Abort everything, including an in-flight multiply.
      state_next     = S_IDLE;
      count_next     = '0;
      mcand_next     = '0;
      mplier_next    = '0;
      prod_next      = '0;
      exp2_next      = '0;
      pend_kind_next = K_NAN;
      out_next       = '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (accept && (in_kind == K_NUM)) begin
            state_next  = S_RUN;
            count_next  = CW'(ITER_MAX);
            mcand_next  = PW'(mant_in);
            mplier_next = mant_in;
            prod_next   = '0;
            exp2_next   = {exp_in, 1'b0};
          end
        end
        S_RUN: begin
          prod_next   = prod_sum;
          mcand_next  = mcand_reg << 1;
          mplier_next = mplier_reg >> 1;
          count_next  = count_reg - CW'(1);
          if (final_iter) begin
            state_next  = S_IDLE;
            out_next    = num_fields;
            result_next = 1'b1;
          end
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase

      // Special classes are answered one edge after acceptance, without
      // ever entering the multiply loop.
      if (accept && (in_kind != K_NUM)) begin
        pend_next      = 1'b1;
        pend_kind_next = in_kind;
      end

      // A pending special and a finishing multiply are mutually exclusive:
      // a special is only accepted while idle and leaves the unit idle.
      if (pend_reg) begin
        out_next    = special_fields(pend_kind_reg);
        result_next = 1'b1;
      end

      it_valid_next = (accept && (in_kind == K_NUM)) ||
                      (state_reg == S_RUN) || pend_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      count_reg     <= '0;
      mcand_reg     <= '0;
      mplier_reg    <= '0;
      prod_reg      <= '0;
      exp2_reg      <= '0;
      pend_reg      <= 1'b0;
      pend_kind_reg <= K_NAN;
      out_reg       <= '0;
      result_reg    <= 1'b0;
      it_valid_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      mcand_reg     <= mcand_next;
      mplier_reg    <= mplier_next;
      prod_reg      <= prod_next;
      exp2_reg      <= exp2_next;
      pend_reg      <= pend_next;
      pend_kind_reg <= pend_kind_next;
      out_reg       <= out_next;
      result_reg    <= result_next;
      it_valid_reg  <= it_valid_next;
    end
  end

  assign it_valid    = it_valid_reg;
  assign result      = result_reg;
  assign sign_out    = out_reg.sign;
  assign exp_out     = out_reg.exp;
  assign mant_out    = out_reg.mant;
  assign is_nan_out  = out_reg.nan;
  assign is_pinf_out = out_reg.pinf;
  assign is_ninf_out = 1'b0;

endmodule

// File: tb/tb_square_iterate.sv
// -----------------------------------------------------------------------------
// tb_square_iterate
//
// Directed bench for square_iterate. Each accepted operation pushes its
// expected fields and due cycle onto a scoreboard; each result pulse pops
// and compares. Also covers reset, enable abort, ignored n_valid, async
// reset mid-operation and back-to-back accepts.
// -----------------------------------------------------------------------------
module tb_square_iterate;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        n_valid;
  logic        is_nan_in;
  logic        is_pinf_in;
  logic        is_ninf_in;
  logic        is_num;
  logic        sign_in;
  logic [10:0] mant_in;
  logic [6:0]  exp_in;
  logic        it_valid;
  logic        result;
  logic        sign_out;
  logic [6:0]  exp_out;
  logic [10:0] mant_out;
  logic        is_nan_out;
  logic        is_pinf_out;
  logic        is_ninf_out;

  square_iterate #(.ITER_MAX(11)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .n_valid    (n_valid),
    .is_nan_in  (is_nan_in),
    .is_pinf_in (is_pinf_in),
    .is_ninf_in (is_ninf_in),
    .is_num     (is_num),
    .sign_in    (sign_in),
    .mant_in    (mant_in),
    .exp_in     (exp_in),
    .it_valid   (it_valid),
    .result     (result),
    .sign_out   (sign_out),
    .exp_out    (exp_out),
    .mant_out   (mant_out),
    .is_nan_out (is_nan_out),
    .is_pinf_out(is_pinf_out),
    .is_ninf_out(is_ninf_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        sign;
    logic [6:0]  exp;
    logic [10:0] mant;
    logic        nan;
    logic        pinf;
    int          due;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
    end
  endtask

  // Reference model: integer multiply, independent of the shift-add loop.
  function automatic exp_t model(input logic nan, input logic pinf, input logic ninf,
                                 input logic num, input logic [10:0] m, input int e);
    exp_t r;
    int   p;
    int   ee;
    r = '{sign: 1'b0, exp: 7'd0, mant: 11'd0, nan: 1'b0, pinf: 1'b0, due: 1};
    if (nan || !num) begin
      r.sign = 1'b1; r.exp = 7'd16; r.mant = 11'h400; r.nan = 1'b1;
    end else if (pinf || ninf) begin
      r.exp = 7'd16; r.pinf = 1'b1;
    end else if (e == -15) begin
      r.exp = 7'(-15);
    end else begin
      r.due = 11;
      p  = int'(m) * int'(m);
      ee = 2 * e;
      if (p >= (1 << 21)) begin
        r.mant = 11'(p >> 11); ee = ee + 1;
      end else begin
        r.mant = 11'(p >> 10);
      end
      if (ee > 15) begin
        r.exp = 7'd16; r.mant = 11'd0; r.pinf = 1'b1;
      end else if (ee < -14) begin
        r.exp = 7'(-15); r.mant = 11'd0;
      end else begin
        r.exp = 7'(ee);
      end
    end
    return r;
  endfunction

  // Drives one request for exactly one edge; caller positions time before
  // the accept edge. Returns at 1 time unit after the accept edge.
  task automatic send(input logic nan, input logic pinf, input logic ninf, input logic num,
                      input logic sgn, input logic [10:0] m, input int e, input bit push);
    exp_t r;
    is_nan_in = nan; is_pinf_in = pinf; is_ninf_in = ninf; is_num = num;
    sign_in = sgn; mant_in = m; exp_in = 7'(e);
    n_valid = 1'b1;
    r = model(nan, pinf, ninf, num, m, e);
    @(posedge clk);
    #1;
    n_valid = 1'b0;
    r.due = r.due + cyc;
    if (push) sb.push_back(r);
  endtask

  task automatic wait_result(input string name);
    int   n;
    exp_t r;
    n = 0;
    while (result !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, "_seen"}, 32'(result), 32'd1);
    if (result === 1'b1) begin
      if (sb.size() == 0) begin
        chk({name, "_sb_nonempty"}, 32'd0, 32'd1);
      end else begin
        r = sb.pop_front();
        $display("result %s: sign=%0d exp=%0d mant=%03h nan=%0d pinf=%0d cyc=%0d",
                 name, sign_out, $signed(exp_out), mant_out, is_nan_out, is_pinf_out, cyc);
        chk({name, "_cycle"}, 32'(cyc),      32'(r.due));
        chk({name, "_sign"},  32'(sign_out), 32'(r.sign));
        chk({name, "_exp"},   32'(exp_out),  32'(r.exp));
        chk({name, "_mant"},  32'(mant_out), 32'(r.mant));
        chk({name, "_nan"},   32'(is_nan_out),  32'(r.nan));
        chk({name, "_pinf"},  32'(is_pinf_out), 32'(r.pinf));
        chk({name, "_ninf"},  32'(is_ninf_out), 32'd0);
        chk({name, "_itv"},   32'(it_valid), 32'd1);
      end
    end
  endtask

  task automatic check_cleared(input string name);
    chk({name, "_result"}, 32'(result),      32'd0);
    chk({name, "_itv"},    32'(it_valid),    32'd0);
    chk({name, "_fields"}, 32'({sign_out, exp_out, mant_out, is_nan_out, is_pinf_out, is_ninf_out}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int hits;
    rst = 1'b1; enable = 1'b0; n_valid = 1'b0;
    is_nan_in = 1'b0; is_pinf_in = 1'b0; is_ninf_in = 1'b0; is_num = 1'b1;
    sign_in = 1'b0; mant_in = '0; exp_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset");
    @(negedge clk);
    rst = 1'b0; enable = 1'b1;

    // -1.5 squared: it_valid held through the result cycle, then drops.
    @(negedge clk);
    send(0, 0, 0, 1, 1, 11'h600, 0, 1);
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      if (it_valid !== 1'b1 || result !== 1'b0) hits++;
      @(posedge clk); #1;
    end
    chk("m1p5_busy_itv", 32'(hits), 32'd0);
    wait_result("m1p5");
    @(posedge clk); #1;
    chk("m1p5_pulse_end", 32'(result), 32'd0);
    chk("m1p5_itv_fall",  32'(it_valid), 32'd0);
    chk("m1p5_hold_mant", 32'(mant_out), 32'h480);

    // Normal results, overflow, underflow, and exponent boundaries.
    @(negedge clk); send(0, 0, 0, 1, 0, 11'h400,  3, 1); wait_result("p8");
    @(negedge clk); send(0, 0, 0, 1, 0, 11'h400,  8, 1); wait_result("ovf");
    @(negedge clk); send(0, 0, 0, 1, 0, 11'h400, -8, 1); wait_result("unf");
    @(negedge clk); send(0, 0, 0, 1, 0, 11'h600,  7, 1); wait_result("emax");
    @(negedge clk); send(0, 0, 0, 1, 0, 11'h600,  8, 1); wait_result("emax_ovf");
    @(negedge clk); send(0, 0, 0, 1, 0, 11'h400, -7, 1); wait_result("emin");
    @(negedge clk); send(0, 0, 0, 1, 1, 11'h7ff,  0, 1); wait_result("allones");

    // Special classes: answered one edge after acceptance.
    @(negedge clk); send(1, 0, 0, 1, 0, 11'h000, 16, 1); wait_result("nan");
    @(negedge clk); send(0, 0, 1, 1, 1, 11'h000, 16, 1); wait_result("ninf");
    @(negedge clk); send(0, 1, 0, 1, 0, 11'h000, 16, 1); wait_result("pinf");
    @(negedge clk); send(0, 0, 0, 0, 0, 11'h400,  2, 1); wait_result("notnum");
    @(negedge clk); send(0, 0, 0, 1, 1, 11'h123, -15, 1); wait_result("zero");

    // Abort via enable after edge 5: nothing comes out.
    @(negedge clk); send(0, 0, 0, 1, 0, 11'h600, 0, 0);
    repeat (5) @(posedge clk);
    @(negedge clk); enable = 1'b0;
    @(posedge clk); #1;
    check_cleared("abort");
    @(negedge clk); enable = 1'b1;
    hits = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (result === 1'b1) hits++;
    end
    chk("abort_no_result", 32'(hits), 32'd0);
    @(negedge clk); send(0, 0, 0, 1, 1, 11'h600, 0, 1); wait_result("after_abort");

    // n_valid pulsed during iteration 4 is ignored.
    @(negedge clk); send(0, 0, 0, 1, 0, 11'h600, 0, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    is_nan_in = 1'b1; n_valid = 1'b1;
    @(negedge clk);
    n_valid = 1'b0; is_nan_in = 1'b0;
    wait_result("ignored_nv");
    hits = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (result === 1'b1) hits++;
    end
    chk("ignored_nv_no_extra", 32'(hits), 32'd0);

    // Back-to-back: accept in the result cycle keeps it_valid high.
    @(negedge clk); send(0, 0, 0, 1, 0, 11'h400, 3, 1); wait_result("b2b_a");
    send(0, 0, 0, 1, 0, 11'h600, 1, 1);
    chk("b2b_itv_held", 32'(it_valid), 32'd1);
    wait_result("b2b_b");

    // Asynchronous reset mid-iteration clears outputs without an edge.
    @(negedge clk); send(0, 0, 0, 1, 0, 11'h400, 3, 0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_cleared("async_rst");
    @(negedge clk); rst = 1'b0;
    @(negedge clk); send(0, 0, 0, 1, 1, 11'h600, 0, 1); wait_result("after_rst");

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/square_iterate.md
Name: square_iterate

Overview:
- Iterative squarer for the unpacked half-precision field format consumed and produced by the sqrt iteration stage. It is the inverse operation of that stage.
- Takes sign, 11-bit mantissa, signed 7-bit exponent and special flags. Computes x*x with an 11-step shift-add multiplier and returns the result in the same field format with the same valid/result handshake.
- Sits between the unpack stage and the repack stage, in parallel with the sqrt unit.

Parameters:
- ITER_MAX, 11, number of multiply iterations; one per mantissa bit.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  synchronous run enable; low clears all state
- n_valid  in  1  input fields valid; accepted only when idle
- is_nan_in  in  1  input is NaN
- is_pinf_in  in  1  input is +inf
- is_ninf_in  in  1  input is -inf
- is_num  in  1  input is a legal number
- sign_in  in  1  input sign
- mant_in  in  11  bit10 = integer bit, bits9:0 = fraction
- exp_in  in  7  signed exponent; -15 = zero/subnormal, 16 = special
- it_valid  out  1  operation in flight or result cycle
- result  out  1  one-cycle pulse, output fields valid
- sign_out  out  1  result sign
- exp_out  out  7  result exponent, signed
- mant_out  out  11  result mantissa, same encoding as mant_in
- is_nan_out  out  1  result is NaN
- is_pinf_out  out  1  result is +inf
- is_ninf_out  out  1  always 0 (square is never -inf)

Behaviour:
- Reset (async) and enable=0 (sync, next edge): all outputs 0, active=0, iteration counter 0, accumulators 0. An in-flight operation is aborted with no result pulse.
- accept = enable & n_valid & ~active. n_valid while active is ignored; there is no queueing.
- Input classes, checked in this priority order:
  - NaN: is_nan_in | ~is_num
  - INF: is_pinf_in | is_ninf_in
  - ZERO: exp_in=-15 (covers zero and all subnormals, whose squares underflow)
  - NUM: everything else, with mant_in[10]=1
- NaN/INF/ZERO accepted at edge k: at edge k+1 (the following edge), result=1 and it_valid=1 for one cycle; active is never set.
  - NaN -> sign 1, exp 16, mant 0x400, is_nan_out=1.
  - INF -> sign 0, exp 16, mant 0, is_pinf_out=1.
  - ZERO -> sign 0, exp -15, mant 0, no flags.
- NUM accepted at edge k: set active, load multiplicand = mant_in, multiplier shift = mant_in, 22-bit product = 0, counter = ITER_MAX, and capture 2*exp_in in 8-bit signed. it_valid=1 from edge k.
- Iteration (active, enable=1), once per edge:
  - If the multiplier LSB is set, add the multiplicand, left-shifted by the iteration index, to the product.
  - Shift the multiplier right by one and decrement the counter.
- Final iteration: the edge where counter goes 1->0, i.e. edge k+11. Using the completed product P[21:0] (unsigned, P/2^20 in [1,4)):
  - P[21]=1 -> mant = P[21:11], e = 2*exp_in+1.
  - else -> mant = P[20:10], e = 2*exp_in.
  - Truncate; no rounding.
  - e > 15 -> INF output (as above). e < -14 -> ZERO output. Otherwise sign 0, exp e[6:0], mant, no flags.
  - At the same edge: result=1, active cleared.
- it_valid falls at the edge after the result cycle unless a new accept occurs at that edge. An accept is allowed in the result cycle (back-to-back).
- Field outputs hold their last result until the next result, rst, or enable=0. They do not change during iterations.
- Sign of a square is always 0, including for negative inputs and -inf.
- Exponent arithmetic is 8-bit signed, so no wrap occurs inside the range check.

Test Plan:
- NUM accept of mant=0x600, exp=0, sign=1 (-1.5) at edge 0 -> result pulse after edge 11; sign 0, mant 0x480, exp 1 (2.25); it_valid high edges 0..11.
- mant=0x400, exp=3 (8.0) -> after 11 iterations: mant 0x400, exp 6, no flags.
- mant=0x400, exp=8 -> INF: is_pinf_out=1, exp 16, mant 0. Separately, mant=0x400, exp=-8 -> ZERO: exp -15, mant 0. Both after 11 iterations.
- is_nan_in=1 -> result at the next edge: sign 1, exp 16, mant 0x400, is_nan_out=1. is_ninf_in=1 -> next edge: is_pinf_out=1, sign 0.
- NUM accepted, enable dropped after edge 5 -> all outputs 0, no result pulse. Re-enable and send 1.5 -> correct 2.25 after 11 iterations.
- NUM in flight: n_valid pulsed at iteration 4 is ignored. rst asserted mid-iteration clears outputs immediately, without a clock edge.
